// File: rtl/sd_cmd_sequencer.sv
// SD command frame sequencer. Takes a command index and argument, loads them into an
// external CRC7 peripheral, polls it until done, reads back the CRC7, and then streams the
// 6-byte SD command frame to an SPI shifter over a valid/ready byte interface.
module sd_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        crc_cs,
  output logic        crc_wr,
  output logic        crc_rd,
  output logic [3:0]  crc_addr,
  output logic [15:0] crc_dout,
  input  logic [15:0] crc_din,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        err
);

  // Sized so that TIMEOUT_CYCLES itself fits without wrapping.
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StWr1,
    StWr2,
    StStart,
    StPoll,
    StRead,
    StSend
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      index_q, index_d;
  logic [31:0]     arg_q, arg_d;
  logic [6:0]      crc7_q, crc7_d;
  logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic            err_q, err_d;

  // Only the low seven bits of a read carry information.
  logic unused_din;
  assign unused_din = ^crc_din[15:7];

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      index_q    <= '0;
      arg_q      <= '0;
      crc7_q     <= '0;
      poll_cnt_q <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      crc7_q     <= crc7_d;
      poll_cnt_q <= poll_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: command latch, peripheral sequencing, poll timeout, byte counting.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    arg_d      = arg_q;
    crc7_d     = crc7_q;
    poll_cnt_d = poll_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          index_d = cmd_index;
          arg_d   = cmd_arg;
          state_d = StWr0;
        end
      end
      StWr0:   state_d = StWr1;
      StWr1:   state_d = StWr2;
      StWr2:   state_d = StStart;
      StStart: begin
        poll_cnt_d = '0;
        state_d    = StPoll;
      end
      StPoll: begin
        if (crc_din[0]) begin
          state_d = StRead;
        end else if (poll_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // This read was the last one allowed: give up without emitting a frame.
          err_d      = 1'b1;
          poll_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          poll_cnt_d = poll_cnt_q + CntW'(1);
        end
      end
      StRead: begin
        crc7_d     = crc_din[6:0];
        byte_cnt_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (byte_cnt_q == 3'd5) begin
            byte_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: peripheral bus strobes and the current frame byte.
  always_comb begin
    cmd_ready = 1'b0;
    crc_cs    = 1'b0;
    crc_wr    = 1'b0;
    crc_rd    = 1'b0;
    crc_addr  = 4'h0;
    crc_dout  = 16'h0000;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    unique case (state_q)
      StIdle: cmd_ready = 1'b1;
      StWr0: begin
        crc_cs   = 1'b1;
        crc_wr   = 1'b1;
        crc_addr = 4'h0;
        crc_dout = {8'h00, 2'b01, index_q};
      end
      StWr1: begin
        crc_cs   = 1'b1;
        crc_wr   = 1'b1;
        crc_addr = 4'h2;
        crc_dout = arg_q[31:16];
      end
      StWr2: begin
        crc_cs   = 1'b1;
        crc_wr   = 1'b1;
        crc_addr = 4'hA;
        crc_dout = arg_q[15:0];
      end
      StStart: begin
        crc_cs   = 1'b1;
        crc_wr   = 1'b1;
        crc_addr = 4'h4;
        crc_dout = 16'h0001;
      end
      StPoll: begin
        crc_cs   = 1'b1;
        crc_rd   = 1'b1;
        crc_addr = 4'h6;
      end
      StRead: begin
        crc_cs   = 1'b1;
        crc_rd   = 1'b1;
        crc_addr = 4'h8;
      end
      StSend: begin
        tx_valid = 1'b1;
        // Byte selection depends only on registered state, so it holds while stalled.
        case (byte_cnt_q)
          3'd0:    tx_data = {2'b01, index_q};
          3'd1:    tx_data = arg_q[31:24];
          3'd2:    tx_data = arg_q[23:16];
          3'd3:    tx_data = arg_q[15:8];
          3'd4:    tx_data = arg_q[7:0];
          default: tx_data = {crc7_q, 1'b1};
        endcase
      end
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: a CRC7 peripheral model, a per-cycle monitor
// and a frame model computed from the SD command format.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        crc_cs, crc_wr, crc_rd;
  logic [3:0]  crc_addr;
  logic [15:0] crc_dout;
  logic [15:0] crc_din;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        err;

  logic tx_ready_man = 1'b0;
  logic tgl = 1'b0;
  logic tgl_phase = 1'b1;
  assign tx_ready = tgl ? tgl_phase : tx_ready_man;

  sd_cmd_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .crc_cs    (crc_cs),
    .crc_wr    (crc_wr),
    .crc_rd    (crc_rd),
    .crc_addr  (crc_addr),
    .crc_dout  (crc_dout),
    .crc_din   (crc_din),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC7 (x^7 + x^3 + 1) over a 40-bit message, MSB first.
  function automatic logic [6:0] crc7_of(input logic [39:0] msg);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ msg[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Full 6-byte frame, first byte in the top bits.
  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_of({2'b01, idx, arg}), 1'b1};
  endfunction

  // CRC7 peripheral model: register file, done flag after done_after polls.
  logic [15:0] reg0 = '0, reg2 = '0, rega = '0;
  int          periph_polls = 0;
  int          done_after = 0;

  always @(posedge clk) begin
    if (crc_cs && crc_wr) begin
      case (crc_addr)
        4'h0: reg0 <= crc_dout;
        4'h2: reg2 <= crc_dout;
        4'hA: rega <= crc_dout;
        4'h4: periph_polls <= 0;
        default: ;
      endcase
    end else if (crc_cs && crc_rd && crc_addr == 4'h6) begin
      periph_polls <= periph_polls + 1;
    end
  end

  always_comb begin
    crc_din = 16'h0000;
    if (crc_cs && crc_rd) begin
      if (crc_addr == 4'h6) crc_din = {15'h7FFF, periph_polls >= done_after};
      else if (crc_addr == 4'h8) crc_din = {9'h1FF, crc7_of({reg0[7:0], reg2, rega})};
    end
  end

  // Toggling tx_ready pattern for stall tests.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tgl) tgl_phase = ~tgl_phase;
    end
  end

  // Monitor: samples mid-cycle, checks cycle invariants, records transactions.
  int          cyc = 0, n_bytes = 0, n_err = 0, n_polls = 0, n_acc = 0, acc_cyc = 0;
  logic [5:0]  acc_idx = '0;
  logic [7:0]  bytes_q[$];
  int          tx_cyc_q[$];
  logic [19:0] wr_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (!crc_cs) check("bus_idle", 32'({crc_wr, crc_rd, crc_addr, crc_dout}), 32'd0);
      if (cmd_ready) check("idle_quiet", 32'({crc_cs, tx_valid}), 32'd0);
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        acc_cyc = cyc;
        acc_idx = cmd_index;
      end
      if (crc_cs && crc_wr) wr_q.push_back({crc_addr, crc_dout});
      if (crc_cs && crc_rd && crc_addr == 4'h6) n_polls++;
      if (tx_valid && tx_ready) begin
        bytes_q.push_back(tx_data);
        tx_cyc_q.push_back(cyc);
        n_bytes++;
      end
      if (err) n_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
    int k;
    k = 0;
    while (!cmd_ready && k < 3000) begin
      step();
      k++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (n_bytes < n && k < 3000) begin
      step();
      k++;
    end
    if (n_bytes < n) check("bytes_timeout", 32'(n_bytes), 32'(n));
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!tx_valid && k < 3000) begin
      step();
      k++;
    end
    if (!tx_valid) check("valid_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic check_frame(input string name, input int base, input logic [47:0] exp);
    if (bytes_q.size() < base + 6) begin
      check({name, "_count"}, 32'(bytes_q.size()), 32'(base + 6));
    end else begin
      for (int i = 0; i < 6; i++)
        check($sformatf("%s_b%0d", name, i), 32'(bytes_q[base+i]), 32'(exp[47-8*i -: 8]));
    end
  endtask

  initial begin
    int bb, wb, pb, eb, ab, k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_bus", 32'({crc_cs, crc_wr, crc_rd, crc_addr, crc_dout}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // CMD0 at minimum latency
    tx_ready_man = 1'b1;
    done_after = 0;
    bb = n_bytes;
    issue(6'd0, 32'h0);
    wait_bytes(bb + 6);
    check_frame("cmd0", bb, 48'h40_00_00_00_00_95);
    check_frame("cmd0_model", bb, frame_of(6'd0, 32'h0));
    if (tx_cyc_q.size() >= bb + 6) begin
      check("lat_first", 32'(tx_cyc_q[bb] - acc_cyc), 32'd7);
      check("lat_last", 32'(tx_cyc_q[bb+5] - acc_cyc), 32'd12);
    end else begin
      check("lat_count", 32'(tx_cyc_q.size()), 32'(bb + 6));
    end
    step();
    check("cmd0_ready_after", 32'(cmd_ready), 32'd1);

    // CMD8 with a few busy polls
    done_after = 3;
    bb = n_bytes;
    wb = wr_q.size();
    pb = n_polls;
    issue(6'd8, 32'h0000_01AA);
    wait_bytes(bb + 6);
    if (wr_q.size() >= wb + 4) begin
      check("cmd8_wr0", 32'(wr_q[wb]), 32'h0_0048);
      check("cmd8_wr1", 32'(wr_q[wb+1]), 32'h2_0000);
      check("cmd8_wr2", 32'(wr_q[wb+2]), 32'hA_01AA);
      check("cmd8_wr3", 32'(wr_q[wb+3]), 32'h4_0001);
    end else begin
      check("cmd8_wr_count", 32'(wr_q.size()), 32'(wb + 4));
    end
    check("cmd8_polls", 32'(n_polls - pb), 32'd4);
    check_frame("cmd8", bb, 48'h48_00_00_01_AA_87);

    // Timeout: done never set
    step();
    done_after = 100000;
    bb = n_bytes;
    pb = n_polls;
    eb = n_err;
    issue(6'd1, 32'h0);
    k = 0;
    while (n_err == eb && k < 3000) begin
      step();
      k++;
    end
    check("to_polls", 32'(n_polls - pb), 32'd255);
    repeat (3) step();
    check("to_err_pulses", 32'(n_err - eb), 32'd1);
    check("to_no_bytes", 32'(n_bytes - bb), 32'd0);
    check("to_ready", 32'(cmd_ready), 32'd1);

    // Stalling tx_ready every other cycle
    done_after = 0;
    bb = n_bytes;
    tgl = 1'b1;
    issue(6'd8, 32'h0000_01AA);
    wait_bytes(bb + 6);
    tgl = 1'b0;
    check_frame("tgl", bb, 48'h48_00_00_01_AA_87);
    step();
    check("tgl_no_extra", 32'(n_bytes - bb), 32'd6);

    // cmd_valid held during SEND with a different command
    bb = n_bytes;
    issue(6'd8, 32'h0000_01AA);
    ab = n_acc;
    wait_valid();
    cmd_valid = 1'b1;
    cmd_index = 6'd55;
    cmd_arg   = 32'h1234_5678;
    wait_bytes(bb + 6);
    check("hold_no_accept", 32'(n_acc - ab), 32'd0);
    check_frame("hold_first", bb, 48'h48_00_00_01_AA_87);
    k = 0;
    while (n_acc == ab && k < 100) begin
      step();
      k++;
    end
    cmd_valid = 1'b0;
    check("hold_acc_idx", 32'(acc_idx), 32'd55);
    wait_bytes(bb + 12);
    check_frame("hold_second", bb + 6, frame_of(6'd55, 32'h1234_5678));

    // Reset in the middle of the third byte
    step();
    tx_ready_man = 1'b0;
    bb = n_bytes;
    issue(6'd9, 32'hDEAD_BEEF);
    wait_valid();
    tx_ready_man = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_ready_man = 1'b0;
    check("mid_bytes", 32'(n_bytes - bb), 32'd2);
    check("mid_third", 32'(tx_data), 32'hAD);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_tx", 32'({tx_valid, tx_data}), 32'd0);
    check("mid_rst_bus", 32'({crc_cs, crc_wr, crc_rd, crc_addr, crc_dout}), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    tx_ready_man = 1'b1;
    repeat (12) step();
    check("mid_no_bytes", 32'(n_bytes - bb), 32'd2);
    bb = n_bytes;
    issue(6'd17, 32'h0);
    wait_bytes(bb + 6);
    check_frame("cmd17", bb, 48'h51_00_00_00_00_55);
    check_frame("cmd17_model", bb, frame_of(6'd17, 32'h0));

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
